// File: rtl/picomips_pkg.sv
// Shared picoMIPS writeback types: flag bit positions, branch condition codes, writeback beat.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package picomips_pkg;

    localparam int DATA_W  = 8;
    localparam int FLAG_W  = 3;
    localparam int RADDR_W = 3;
    localparam int COND_W  = 3;

    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [COND_W-1:0] {
        COND_NEVER  = 3'd0,
        COND_ALWAYS = 3'd1,
        COND_EQ     = 3'd2,
        COND_NE     = 3'd3,
        COND_LT     = 3'd4,
        COND_GE     = 3'd5,
        COND_VS     = 3'd6,
        COND_VC     = 3'd7
    } cond_e;

    typedef struct packed {
        logic [DATA_W-1:0]  result;
        logic [RADDR_W-1:0] rd;
        logic               we;
        logic               branch;
    } wb_beat_t;

    typedef enum logic [1:0] {
        WB_EMPTY = 2'd0,
        WB_FULL  = 2'd1,
        WB_SKID  = 2'd2
    } wb_state_e;

    function automatic logic cond_eval(input cond_e cond, input logic [FLAG_W-1:0] flags);
        logic taken;
        case (cond)
            COND_NEVER:  taken = 1'b0;
            COND_ALWAYS: taken = 1'b1;
            COND_EQ:     taken = flags[FLAG_Z];
            COND_NE:     taken = ~flags[FLAG_Z];
            COND_LT:     taken = flags[FLAG_N] ^ flags[FLAG_V];
            COND_GE:     taken = ~(flags[FLAG_N] ^ flags[FLAG_V]);
            COND_VS:     taken = flags[FLAG_V];
            COND_VC:     taken = ~flags[FLAG_V];
            default:     taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// Valid/ready register slice for one writeback beat; DEPTH=1 single entry, DEPTH=2 adds a skid entry.
// Latency: 1 cycle from accept to out_valid when empty; full throughput on simultaneous accept+drain.
// Backpressure: DEPTH=1 in_ready = ~out_valid | out_ready; DEPTH=2 in_ready is a flop, low only when the skid entry is occupied.
module wb_skid_buffer
    import picomips_pkg::*;
#(
    parameter type T     = wb_beat_t,
    parameter int  DEPTH = 1
) (
    input  logic clk,
    input  logic n_reset,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_dat,
    output logic out_valid,
    input  logic out_ready,
    output T     out_dat
);

    wb_state_e state_q, state_d;
    T          main_q, skid_q;
    logic      rdy_q;
    logic      accept, drain;
    logic      main_ld, main_from_skid, skid_ld;

    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign out_valid = (state_q != WB_EMPTY);
    assign out_dat   = main_q;

    // rdy_q also keeps in_ready low during reset and for the first edge after release.
    generate
        if (DEPTH > 1) begin : g_skid_rdy
            assign in_ready = rdy_q;
        end else begin : g_single_rdy
            assign in_ready = rdy_q & (~out_valid | out_ready);
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        case (state_q)
            WB_EMPTY: begin
                if (accept) begin
                    state_d = WB_FULL;
                    main_ld = 1'b1;
                end
            end
            WB_FULL: begin
                if (drain && accept) begin
                    main_ld = 1'b1;
                end else if (drain) begin
                    state_d = WB_EMPTY;
                end else if (accept) begin
                    state_d = WB_SKID;
                    skid_ld = 1'b1;
                end
            end
            WB_SKID: begin
                if (drain) begin
                    state_d        = WB_FULL;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = WB_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= WB_EMPTY;
            rdy_q   <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != WB_SKID);
            if (main_from_skid) begin
                main_q <= skid_q;
            end else if (main_ld) begin
                main_q <= in_dat;
            end
            if (skid_ld) begin
                skid_q <= in_dat;
            end
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// picoMIPS execute->writeback stage: registers ALU beat, owns flags register, resolves branch condition. Optional macro ALU_WB_SKID_EN.
// Latency: 1 cycle accept->out_valid; flags_q updates the edge after an accept with in_flag_we, even while the output stalls.
// Backpressure: without ALU_WB_SKID_EN in_ready = ~out_valid | out_ready; with it a 2-entry skid and registered in_ready.
module alu_writeback_stage
    import picomips_pkg::*;
#(
    parameter int BUS_WIDTH      = DATA_W,
    parameter int FLAG_WIDTH     = FLAG_W,
    parameter int REG_ADDR_WIDTH = RADDR_W,
    parameter int COND_WIDTH     = COND_W
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BUS_WIDTH-1:0]      in_result,
    input  logic [FLAG_WIDTH-1:0]     in_flags,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_we,
    input  logic                      in_flag_we,
    input  logic [COND_WIDTH-1:0]     in_cond,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BUS_WIDTH-1:0]      out_result,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_we,
    output logic                      out_branch,
    output logic [FLAG_WIDTH-1:0]     flags_q
);

`ifdef ALU_WB_SKID_EN
    localparam int WB_DEPTH = 2;
`else
    localparam int WB_DEPTH = 1;
`endif

    logic                  accept;
    logic [FLAG_WIDTH-1:0] eff_flags;
    wb_beat_t              in_beat, out_beat;

    assign accept = in_valid & in_ready;

    // A beat that writes flags branches on its own flags, not the stale register.
    assign eff_flags = in_flag_we ? in_flags : flags_q;

    always_comb begin
        in_beat        = '0;
        in_beat.result = in_result;
        in_beat.rd     = in_rd;
        in_beat.we     = in_we;
        in_beat.branch = cond_eval(cond_e'(in_cond), eff_flags);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            flags_q <= '0;
        end else if (accept && in_flag_we) begin
            flags_q <= in_flags;
        end
    end

    wb_skid_buffer #(
        .T     (wb_beat_t),
        .DEPTH (WB_DEPTH)
    ) u_wb_buf (
        .clk       (clk),
        .n_reset   (n_reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dat    (in_beat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dat   (out_beat)
    );

    assign out_result = out_beat.result;
    assign out_rd     = out_beat.rd;
    assign out_we     = out_beat.we;
    assign out_branch = out_beat.branch;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: directed scenarios plus randomized traffic against a flag/branch reference model.
module tb_alu_writeback_stage;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_result;
    logic [2:0] in_flags;
    logic [2:0] in_rd;
    logic       in_we;
    logic       in_flag_we;
    logic [2:0] in_cond;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [2:0] out_rd;
    logic       out_we;
    logic       out_branch;
    logic [2:0] flags_q;

`ifdef ALU_WB_SKID_EN
    localparam int EXP_BP = 2;
`else
    localparam int EXP_BP = 1;
`endif

    alu_writeback_stage dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .in_flag_we (in_flag_we),
        .in_cond    (in_cond),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_we     (out_we),
        .out_branch (out_branch),
        .flags_q    (flags_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] result;
        logic [2:0] rd;
        logic       we;
        logic       branch;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] mdl_flags = 3'b000;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_out = 0;
    int         streak = 0;
    int         max_streak = 0;
    int         cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Condition table: flags are {V,N,Z}.
    function automatic logic ref_branch(input logic [2:0] cond, input logic [2:0] f);
        logic v, n, z;
        v = f[2];
        n = f[1];
        z = f[0];
        case (cond)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd2: return z;
            3'd3: return !z;
            3'd4: return n != v;
            3'd5: return n == v;
            3'd6: return v;
            default: return !v;
        endcase
    endfunction

    // Reference model: sees each accept mid-cycle, predicts the beat and the flags register.
    always @(negedge clk) begin : model_p
        exp_t e;
        if (!n_reset) begin
            exp_q.delete();
            mdl_flags = 3'b000;
        end else begin
            check("flags_q", {29'd0, flags_q}, {29'd0, mdl_flags});
            if (in_valid && in_ready) begin
                e.result = in_result;
                e.rd     = in_rd;
                e.we     = in_we;
                e.branch = ref_branch(in_cond, in_flag_we ? in_flags : mdl_flags);
                exp_q.push_back(e);
                if (in_flag_we) mdl_flags = in_flags;
            end
        end
    end

    // Monitor: compares every presented beat (held or transferring) with the queue head.
    always @(negedge clk) begin : monitor_p
        exp_t e;
        if (n_reset && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: actual result=%0h required no beat (t=%0t)", out_result, $time);
            end else begin
                e = exp_q[0];
                check("out_result", {24'd0, out_result}, {24'd0, e.result});
                check("out_rd", {29'd0, out_rd}, {29'd0, e.rd});
                check("out_we", {31'd0, out_we}, {31'd0, e.we});
                check("out_branch", {31'd0, out_branch}, {31'd0, e.branch});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                    streak++;
                    if (streak > max_streak) max_streak = streak;
                end
            end
        end
        if (!(n_reset && out_valid && out_ready)) streak = 0;
    end

    task automatic set_beat(input logic [7:0] r, input logic [2:0] rd, input logic we,
                            input logic fwe, input logic [2:0] fl, input logic [2:0] c);
        in_valid   = 1'b1;
        in_result  = r;
        in_rd      = rd;
        in_we      = we;
        in_flag_we = fwe;
        in_flags   = fl;
        in_cond    = c;
    endtask

    // Presents a beat and returns 1 ns after the edge that accepted it.
    task automatic drive(input logic [7:0] r, input logic [2:0] rd, input logic we,
                         input logic fwe, input logic [2:0] fl, input logic [2:0] c);
        logic got;
        got = 1'b0;
        set_beat(r, rd, we, fwe, fl, c);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        check("accept", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        logic done;
        done      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        check("drain_empty", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Offers consecutive beats for n cycles, advancing only on accept.
    task automatic offer(input int ncyc, input logic fwe, input logic [2:0] fl,
                         output int acc, output logic last_rdy);
        int idx;
        idx = 0;
        acc = 0;
        last_rdy = 1'b0;
        set_beat(8'hA0, 3'd0, 1'b1, fwe, fl, 3'd1);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            last_rdy = in_ready;
            if (in_ready) acc++;
            @(posedge clk);
            #1;
            if (last_rdy) begin
                idx++;
                set_beat(8'hA0 + 8'(idx), 3'(idx), 1'b1, fwe, fl, 3'(idx));
            end
        end
    endtask

    initial begin
        int   acc;
        logic rdy;
        int   n0;
        int   c0;

        n_reset    = 1'b0;
        in_valid   = 1'b0;
        in_result  = 8'h00;
        in_flags   = 3'b000;
        in_rd      = 3'd0;
        in_we      = 1'b0;
        in_flag_we = 1'b0;
        in_cond    = 3'd0;
        out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_flags", {29'd0, flags_q}, 32'd0);
        check("rst_result", {24'd0, out_result}, 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        #1;
        check("release_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("release_in_ready_high", {31'd0, in_ready}, 32'd1);

        // Single beat, one-cycle latency.
        drive(8'h3C, 3'd5, 1'b1, 1'b1, 3'b000, 3'd0);
        in_valid = 1'b0;
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_result", {24'd0, out_result}, 32'h3C);
        check("single_rd", {29'd0, out_rd}, 32'd5);
        check("single_flags", {29'd0, flags_q}, 32'd0);

        // Branch resolution against written and held flags.
        drive(8'h01, 3'd1, 1'b1, 1'b1, 3'b001, 3'd0);
        drive(8'h02, 3'd2, 1'b1, 1'b0, 3'b000, 3'd2);
        check("branch_eq", {31'd0, out_branch}, 32'd1);
        drive(8'h03, 3'd3, 1'b0, 1'b1, 3'b110, 3'd4);
        in_valid = 1'b0;
        check("branch_lt", {31'd0, out_branch}, 32'd0);
        check("no_we_passes", {31'd0, out_we}, 32'd0);
        wait_drain();

        // Back-pressure: three stalled cycles with a beat always offered.
        out_ready = 1'b0;
        n0 = n_out;
        offer(3, 1'b0, 3'b000, acc, rdy);
        check("bp_accepts", acc, EXP_BP);
        check("bp_ready_3rd", {31'd0, rdy}, 32'd0);
        wait_drain();
        check("bp_outputs", n_out - n0, EXP_BP);

        // Reset while stalled with beats held.
        out_ready = 1'b0;
        offer(2, 1'b1, 3'b111, acc, rdy);
        check("held_before_reset", {31'd0, out_valid}, 32'd1);
        #2;
        n_reset = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", {24'd0, out_result}, 32'd0);
        check("mid_rst_rd", {29'd0, out_rd}, 32'd0);
        check("mid_rst_we", {31'd0, out_we}, 32'd0);
        check("mid_rst_branch", {31'd0, out_branch}, 32'd0);
        check("mid_rst_flags", {29'd0, flags_q}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_release_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_release_valid", {31'd0, out_valid}, 32'd0);

        // Streaming: 16 back-to-back beats, one per cycle.
        max_streak = 0;
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            drive(8'(i), 3'(i), 1'b1, 1'b0, 3'b000, 3'd1);
            if (i == 0) check("stream_latency", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        check("stream_cycles", cyc - c0, 32'd16);
        @(posedge clk);
        #1;
        check("stream_consecutive", max_streak, 32'd16);
        wait_drain();

        // Flags register updates on accept even while the output is stalled.
        drive(8'h55, 3'd1, 1'b1, 1'b0, 3'b000, 3'd1);
`ifdef ALU_WB_SKID_EN
        out_ready = 1'b0;
        drive(8'h66, 3'd2, 1'b1, 1'b1, 3'b100, 3'd4);
        in_valid = 1'b0;
        check("stall_flags", {29'd0, flags_q}, 32'b100);
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_held_result", {24'd0, out_result}, 32'h55);
`else
        drive(8'h66, 3'd2, 1'b1, 1'b1, 3'b100, 3'd4);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stall_flags", {29'd0, flags_q}, 32'b100);
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_held_result", {24'd0, out_result}, 32'h66);
`endif
        @(posedge clk);
        #1;
        check("stall_flags_hold", {29'd0, flags_q}, 32'b100);
        wait_drain();

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_result  = 8'($urandom);
            in_rd      = 3'($urandom);
            in_we      = 1'($urandom_range(0, 1));
            in_flag_we = 1'($urandom_range(0, 1));
            in_flags   = 3'($urandom);
            in_cond    = 3'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        wait_drain();
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
